// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package rapids_fetch_pkg;

  localparam int WORD_W = 32;

  // Sequential fetch advances by one 32-bit word.
  localparam logic [WORD_W-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and memory.
interface instr_fetch_unit_if;
  import rapids_fetch_pkg::*;

  logic              req;
  logic [WORD_W-1:0] addr;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/instr_fetch_unit_bounds.sv
// Combinational legality check of a fetch address: word aligned and inside
// the [IMEM_BASE, IMEM_LIMIT) window.
module fetch_bounds_check
  import rapids_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] IMEM_BASE  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] IMEM_LIMIT = 32'h0001_0000
) (
  input  logic [WORD_W-1:0] addr,
  output logic              legal
);

  logic [WORD_W-1:0] offset;

  // Addresses below the base wrap to huge offsets, so a single unsigned
  // compare against the window size covers both bounds.
  always_comb begin
    offset = addr - IMEM_BASE;
    legal  = (addr[1:0] == 2'b00) && (offset < (IMEM_LIMIT - IMEM_BASE));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over the imem bus and presents a
// stable instruction register to the control path.
module instr_fetch_unit
  import rapids_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [WORD_W-1:0] IMEM_BASE  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] IMEM_LIMIT = 32'h0001_0000,
  parameter int                TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic                      halt,
  input  logic                      pc_inc,
  input  logic                      pc_load,
  input  logic [WORD_W-1:0]         pc_target,
  instr_fetch_unit_if.master        imem,
  output logic [WORD_W-1:0]         instruction,
  output logic                      wait_instr,
  output logic                      instr_segv,
  output logic [WORD_W-1:0]         pc
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] instr_next;
  logic [WORD_W-1:0] cand_pc;
  logic              cand_legal;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  // The PC that would be fetched next: the current PC when starting from
  // IDLE, otherwise the redirect target or the sequential successor.
  always_comb begin
    cand_pc = pc;
    if (state == VALID) begin
      if (pc_load) begin
        cand_pc = pc_target;
      end else begin
        cand_pc = pc + PC_INCR;
      end
    end
  end

  fetch_bounds_check #(
    .IMEM_BASE (IMEM_BASE),
    .IMEM_LIMIT(IMEM_LIMIT)
  ) u_bounds (
    .addr (cand_pc),
    .legal(cand_legal)
  );

  // Next-state logic; halt wins over every other request in the live states.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    count_next = '0;
    unique case (state)
      IDLE: begin
        if (!halt && go) begin
          state_next = cand_legal ? FETCH : FAULT;
        end
      end
      FETCH: begin
        if (halt) begin
          state_next = IDLE;
        end else if (imem.ack) begin
          instr_next = imem.rdata;
          state_next = VALID;
        end else if (count == CNT_LAST) begin
          state_next = FAULT;
        end else begin
          count_next = count + 1'b1;
        end
      end
      VALID: begin
        if (halt) begin
          state_next = IDLE;
        end else if (pc_load || pc_inc) begin
          pc_next    = cand_pc;
          state_next = cand_legal ? FETCH : FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC, instruction register and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      count       <= count_next;
    end
  end

  // Control-path and bus outputs are decoded from registered state only.
  always_comb begin
    imem.req   = (state == FETCH);
    imem.addr  = pc;
    wait_instr = (state != VALID);
    instr_segv = (state == FAULT);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a spec-level reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0001_0000;
  localparam int          TIMEOUT    = 16;

  logic        clk;
  logic        reset;
  logic        go;
  logic        halt;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] instruction;
  logic        wait_instr;
  logic        instr_segv;
  logic [31:0] pc;

  int checks;
  int passes;

  logic [31:0] model_pc;
  logic [31:0] model_instr;

  instr_fetch_unit_if imem ();

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_BASE (IMEM_BASE),
    .IMEM_LIMIT(IMEM_LIMIT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .halt       (halt),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .imem       (imem.master),
    .instruction(instruction),
    .wait_instr (wait_instr),
    .instr_segv (instr_segv),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit model_legal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la % 4 == 0) && (la >= longint'(IMEM_BASE)) && (la < longint'(IMEM_LIMIT));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit g, input bit h, input bit inc, input bit ld,
                               input logic [31:0] tgt);
    go        = g;
    halt      = h;
    pc_inc    = inc;
    pc_load   = ld;
    pc_target = tgt;
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 32'h0);
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    reset      = 1'b1;
    tick();
    tick();
    reset       = 1'b0;
    model_pc    = RESET_PC;
    model_instr = 32'h0;
  endtask

  // Expects to be called right after the edge that entered FETCH.
  task automatic fetch_with_ack(input int delay, input logic [31:0] data,
                                input logic [31:0] exp_addr, input string tag);
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== exp_addr || wait_instr !== 1'b1)
        $display("[TB] FAIL %s_fetch: req=%b addr=%h wait=%b, expected req=1 addr=%h wait=1",
                 tag, imem.req, imem.addr, wait_instr, exp_addr);
      else passes++;
      if (i < delay) tick();
    end
    imem.ack   = 1'b1;
    imem.rdata = data;
    tick();
    imem.ack   = 1'b0;
    imem.rdata = $urandom;
    model_instr = data;
    checks++;
    if (wait_instr !== 1'b0 || instruction !== data || imem.req !== 1'b0 || instr_segv !== 1'b0)
      $display("[TB] FAIL %s_valid: wait=%b instr=%h req=%b segv=%b, expected wait=0 instr=%h req=0 segv=0",
               tag, wait_instr, instruction, imem.req, instr_segv, data);
    else passes++;
  endtask

  task automatic reach_valid(input logic [31:0] data);
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    fetch_with_ack($urandom_range(0, 3), data, model_pc, "reach");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== RESET_PC || instruction !== 32'h0 || wait_instr !== 1'b1 ||
        instr_segv !== 1'b0 || imem.req !== 1'b0)
      $display("[TB] FAIL reset_state: pc=%h instr=%h wait=%b segv=%b req=%b, expected %h 0 1 0 0",
               pc, instruction, wait_instr, instr_segv, imem.req, RESET_PC);
    else passes++;
    // go must not be required to be held; idle stays idle without it
    tick();
    checks++;
    if (imem.req !== 1'b0 || wait_instr !== 1'b1)
      $display("[TB] FAIL reset_idle: req=%b wait=%b, expected req=0 wait=1", imem.req, wait_instr);
    else passes++;
  endtask

  task automatic test_go();
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    fetch_with_ack(2, 32'hDEAD_BEE1, 32'h0, "go");
  endtask

  task automatic test_inc_sequence();
    reach_valid($urandom);
    for (int k = 0; k < 3; k++) begin
      model_pc = model_pc + 32'd4;
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      checks++;
      if (pc !== model_pc)
        $display("[TB] FAIL inc_pc: pc=%h expected %h", pc, model_pc);
      else passes++;
      fetch_with_ack(0, $urandom, model_pc, "inc");
    end
  endtask

  task automatic test_priority();
    reach_valid($urandom);
    applyStimulus(0, 0, 1, 1, 32'h100);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0);
    model_pc = 32'h100;
    checks++;
    if (pc !== 32'h100)
      $display("[TB] FAIL load_priority: pc=%h expected %h", pc, 32'h100);
    else passes++;
    fetch_with_ack($urandom_range(0, 2), $urandom, 32'h100, "load");
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    int          op;
    reach_valid($urandom);
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      if (op == 1 && !model_legal(model_pc + 32'd4)) op = 2;
      if (op == 0) begin
        tick();
        checks++;
        if (wait_instr !== 1'b0 || instruction !== model_instr || pc !== model_pc || imem.req !== 1'b0)
          $display("[TB] FAIL rand_hold: wait=%b instr=%h pc=%h req=%b, expected 0 %h %h 0",
                   wait_instr, instruction, pc, imem.req, model_instr, model_pc);
        else passes++;
      end else begin
        if (op == 1) begin
          nxt = model_pc + 32'd4;
          applyStimulus(0, 0, 1, 0, $urandom);
        end else begin
          nxt = ($urandom_range(0, 7) == 0) ? (IMEM_LIMIT - 32'd4)
                                            : ($urandom_range(0, 16383) * 4);
          applyStimulus(0, 0, $urandom_range(0, 1), 1, nxt);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0);
        model_pc = nxt;
        checks++;
        if (pc !== model_pc)
          $display("[TB] FAIL rand_pc: pc=%h expected %h", pc, model_pc);
        else passes++;
        fetch_with_ack($urandom_range(0, 4), $urandom, model_pc, "rand");
      end
    end
  endtask

  task automatic test_fault_target();
    logic [31:0] bad [4];
    bad[0] = 32'h0001_0000;
    bad[1] = 32'h0000_0102;
    bad[2] = 32'hFFFF_FFFC;
    bad[3] = 32'h0000_FFFE;
    foreach (bad[j]) begin
      reach_valid($urandom);
      applyStimulus(0, 0, $urandom_range(0, 1), 1, bad[j]);
      tick();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (instr_segv !== 1'b1 || wait_instr !== 1'b1 || imem.req !== 1'b0 || pc !== bad[j])
          $display("[TB] FAIL fault_hold: segv=%b wait=%b req=%b pc=%h, expected 1 1 0 %h",
                   instr_segv, wait_instr, imem.req, pc, bad[j]);
        else passes++;
        applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), 32'h40);
        imem.ack   = $urandom_range(0, 1);
        imem.rdata = $urandom;
        tick();
      end
      imem.ack = 1'b0;
      do_reset();
      checks++;
      if (instr_segv !== 1'b0 || pc !== RESET_PC)
        $display("[TB] FAIL fault_reset: segv=%b pc=%h, expected 0 %h", instr_segv, pc, RESET_PC);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] late;
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++;
      if (imem.req !== 1'b1 || instr_segv !== 1'b0)
        $display("[TB] FAIL timeout_req cycle %0d: req=%b segv=%b, expected req=1 segv=0",
                 i, imem.req, instr_segv);
      else passes++;
      tick();
    end
    checks++;
    if (instr_segv !== 1'b1 || imem.req !== 1'b0 || wait_instr !== 1'b1)
      $display("[TB] FAIL timeout_fault: segv=%b req=%b wait=%b, expected 1 0 1",
               instr_segv, imem.req, wait_instr);
    else passes++;
    late       = $urandom;
    imem.ack   = 1'b1;
    imem.rdata = late;
    tick();
    tick();
    imem.ack = 1'b0;
    checks++;
    if (instruction !== 32'h0 || wait_instr !== 1'b1 || instr_segv !== 1'b1)
      $display("[TB] FAIL timeout_late_ack: instr=%h wait=%b segv=%b, expected 0 1 1",
               instruction, wait_instr, instr_segv);
    else passes++;
    // an ack on the very last permitted cycle still completes the fetch
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    fetch_with_ack(TIMEOUT - 1, 32'h1234_5678, RESET_PC, "timeout_edge");
  endtask

  task automatic test_halt();
    logic [31:0] held;
    held = $urandom;
    reach_valid(held);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    model_pc = model_pc + 32'd4;
    halt = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = $urandom;
    tick();
    halt = 1'b0;
    checks++;
    if (imem.req !== 1'b0 || wait_instr !== 1'b1 || instruction !== held || pc !== model_pc)
      $display("[TB] FAIL halt_fetch: req=%b wait=%b instr=%h pc=%h, expected 0 1 %h %h",
               imem.req, wait_instr, instruction, pc, held, model_pc);
    else passes++;
    tick();
    imem.ack = 1'b0;
    checks++;
    if (instruction !== held || wait_instr !== 1'b1)
      $display("[TB] FAIL halt_late_ack: instr=%h wait=%b, expected %h 1", instruction, wait_instr, held);
    else passes++;
    go = 1'b1;
    tick();
    go = 1'b0;
    fetch_with_ack(1, $urandom, model_pc, "halt_resume");
    applyStimulus(0, 1, 1, 1, 32'h200);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0);
    checks++;
    if (pc !== model_pc || wait_instr !== 1'b1 || imem.req !== 1'b0 || instruction !== model_instr)
      $display("[TB] FAIL halt_valid: pc=%h wait=%b req=%b instr=%h, expected %h 1 0 %h",
               pc, wait_instr, imem.req, instruction, model_pc, model_instr);
    else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    reach_valid($urandom);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    reset = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = 32'hCAFE_F00D;
    tick();
    checks++;
    if (pc !== RESET_PC || instruction !== 32'h0 || wait_instr !== 1'b1 ||
        instr_segv !== 1'b0 || imem.req !== 1'b0)
      $display("[TB] FAIL reset_mid_fetch: pc=%h instr=%h wait=%b segv=%b req=%b, expected %h 0 1 0 0",
               pc, instruction, wait_instr, instr_segv, imem.req, RESET_PC);
    else passes++;
    reset = 1'b0;
    tick();
    imem.ack = 1'b0;
    checks++;
    if (instruction !== 32'h0 || wait_instr !== 1'b1 || imem.req !== 1'b0)
      $display("[TB] FAIL reset_late_ack: instr=%h wait=%b req=%b, expected 0 1 0",
               instruction, wait_instr, imem.req);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    reset     = 1'b1;
    imem.ack  = 1'b0;
    imem.rdata = 32'h0;
    applyStimulus(0, 0, 0, 0, 32'h0);
    test_reset();
    test_go();
    test_inc_sequence();
    test_priority();
    test_random();
    test_fault_target();
    test_timeout();
    test_halt();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
